// File: rtl/time_set_ctrl.sv
// Manual time-setting sequencer: captures the running time, steps a field cursor and
// increments/decrements shadows, then strobes load. Optional key_dec via TIME_SET_DEC_EN.
module time_set_ctrl #(
    parameter int TIMEOUT = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mode_en,
    input  logic       key_sel,
    input  logic       key_inc,
`ifdef TIME_SET_DEC_EN
    input  logic       key_dec,
`endif
    input  logic       tick_2hz,
    input  logic [4:0] hour_in,
    input  logic [5:0] min_in,
    input  logic [5:0] sec_in,
    output logic       set_active,
    output logic [1:0] field_sel,
    output logic       blink,
    output logic [4:0] hour_set,
    output logic [5:0] min_set,
    output logic [5:0] sec_set,
    output logic       load
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT);

    typedef enum logic [2:0] {IDLE, EDIT_HR, EDIT_MIN, EDIT_SEC, COMMIT} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [4:0]       hour_nxt;
    logic [5:0]       min_nxt, sec_nxt;
    logic             blink_nxt;
    logic             edit_nxt;
    logic [1:0]       field_nxt;
    logic             dec_key;

`ifdef TIME_SET_DEC_EN
    assign dec_key = key_dec;
`else
    assign dec_key = 1'b0;
`endif

    function automatic logic [4:0] hour_step(input logic [4:0] h, input logic up);
        if (up) return (h >= 5'd23) ? 5'd0 : h + 5'd1;
        return (h == 5'd0 || h > 5'd23) ? 5'd23 : h - 5'd1;
    endfunction

    function automatic logic [5:0] sexa_step(input logic [5:0] v, input logic up);
        if (up) return (v >= 6'd59) ? 6'd0 : v + 6'd1;
        return (v == 6'd0 || v > 6'd59) ? 6'd59 : v - 6'd1;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c >= CNT_LIM) ? CNT_LIM : c + 1'b1;
    endfunction

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        hour_nxt  = hour_set;
        min_nxt   = min_set;
        sec_nxt   = sec_set;
        blink_nxt = blink;
        case (state)
            IDLE: begin
                if (key_sel && mode_en) begin
                    state_nxt = EDIT_HR;
                    hour_nxt  = hour_in;
                    min_nxt   = min_in;
                    sec_nxt   = sec_in;
                    blink_nxt = 1'b1;
                end
            end
            EDIT_HR, EDIT_MIN, EDIT_SEC: begin
                // Mode drop beats every key and the timeout.
                if (!mode_en) begin
                    state_nxt = IDLE;
                end else if (key_sel) begin
                    cnt_nxt = '0;
                    case (state)
                        EDIT_HR:  state_nxt = EDIT_MIN;
                        EDIT_MIN: state_nxt = EDIT_SEC;
                        default:  state_nxt = COMMIT;
                    endcase
                end else if (key_inc || dec_key) begin
                    cnt_nxt = '0;
                    case (state)
                        EDIT_HR:  hour_nxt = hour_step(hour_set, key_inc);
                        EDIT_MIN: min_nxt  = sexa_step(min_set, key_inc);
                        default:  sec_nxt  = sexa_step(sec_set, key_inc);
                    endcase
                end else if (tick_2hz) begin
                    cnt_nxt = sat_inc(cnt);
                    if (cnt_nxt >= CNT_LIM) state_nxt = IDLE;
                end
                if (key_sel || key_inc || dec_key) blink_nxt = 1'b1;
                else if (tick_2hz)                 blink_nxt = ~blink;
            end
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        edit_nxt  = (state_nxt == EDIT_HR) || (state_nxt == EDIT_MIN) || (state_nxt == EDIT_SEC);
        field_nxt = 2'b00;
        case (state_nxt)
            EDIT_HR:  field_nxt = 2'b01;
            EDIT_MIN: field_nxt = 2'b10;
            EDIT_SEC: field_nxt = 2'b11;
            default:  field_nxt = 2'b00;
        endcase
        if (!edit_nxt) begin
            blink_nxt = 1'b0;
            cnt_nxt   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            set_active <= 1'b0;
            field_sel  <= 2'b00;
            blink      <= 1'b0;
            load       <= 1'b0;
            hour_set   <= '0;
            min_set    <= '0;
            sec_set    <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            set_active <= edit_nxt;
            field_sel  <= field_nxt;
            blink      <= blink_nxt;
            load       <= (state_nxt == COMMIT);
            hour_set   <= hour_nxt;
            min_set    <= min_nxt;
            sec_set    <= sec_nxt;
        end
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Randomised bench for time_set_ctrl against a field-index reference model.
module tb_time_set_ctrl;

    localparam int TIMEOUT = 20;
`ifdef TIME_SET_DEC_EN
    localparam bit HAS_DEC = 1'b1;
`else
    localparam bit HAS_DEC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mode_en = 1'b1;
    logic       key_sel = 1'b0;
    logic       key_inc = 1'b0;
    logic       key_dec = 1'b0;
    logic       tick_2hz = 1'b0;
    logic [4:0] hour_in = '0;
    logic [5:0] min_in = '0;
    logic [5:0] sec_in = '0;
    logic       set_active;
    logic [1:0] field_sel;
    logic       blink;
    logic [4:0] hour_set;
    logic [5:0] min_set;
    logic [5:0] sec_set;
    logic       load;

    int checks = 0;
    int errors = 0;

    // Model: field 0 = idle, 1..3 = hours/minutes/seconds, 4 = commit.
    int m_field, m_hr, m_min, m_sec, m_cnt, m_blink, m_load;

    time_set_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .mode_en(mode_en), .key_sel(key_sel), .key_inc(key_inc),
`ifdef TIME_SET_DEC_EN
        .key_dec(key_dec),
`endif
        .tick_2hz(tick_2hz), .hour_in(hour_in), .min_in(min_in), .sec_in(sec_in),
        .set_active(set_active), .field_sel(field_sel), .blink(blink),
        .hour_set(hour_set), .min_set(min_set), .sec_set(sec_set), .load(load)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_field = 0; m_hr = 0; m_min = 0; m_sec = 0; m_cnt = 0; m_blink = 0; m_load = 0;
    endtask

    task automatic model_step(input bit s, input bit i, input bit d, input bit t, input bit m);
        if (m_field == 0) begin
            if (s && m) begin
                m_field = 1; m_hr = hour_in; m_min = min_in; m_sec = sec_in;
                m_blink = 1; m_cnt = 0;
            end
        end else if (m_field == 4) begin
            m_field = 0;
        end else if (!m) begin
            m_field = 0;
        end else if (s) begin
            m_field++; m_cnt = 0; m_blink = 1;
        end else if (i || d) begin
            int delta = i ? 1 : -1;
            m_cnt = 0; m_blink = 1;
            if (m_field == 1)      m_hr  = (m_hr + delta + 24) % 24;
            else if (m_field == 2) m_min = (m_min + delta + 60) % 60;
            else                   m_sec = (m_sec + delta + 60) % 60;
        end else if (t) begin
            m_cnt = (m_cnt + 1 > TIMEOUT) ? TIMEOUT : m_cnt + 1;
            m_blink = !m_blink;
            if (m_cnt >= TIMEOUT) m_field = 0;
        end
        if (m_field == 0 || m_field == 4) begin
            m_blink = 0; m_cnt = 0;
        end
        m_load = (m_field == 4);
    endtask

    task automatic compare_all();
        int fs = (m_field >= 1 && m_field <= 3) ? m_field : 0;
        check("set_active", set_active, (fs != 0));
        check("field_sel", field_sel, fs);
        check("blink", blink, m_blink);
        check("load", load, m_load);
        check("hour_set", hour_set, m_hr);
        check("min_set", min_set, m_min);
        check("sec_set", sec_set, m_sec);
    endtask

    task automatic step(input bit s, input bit i, input bit d, input bit t, input bit m);
        key_sel = s; key_inc = i; key_dec = d && HAS_DEC; tick_2hz = t; mode_en = m;
        @(posedge clk);
        model_step(s, i, d && HAS_DEC, t, m);
        #1;
        key_sel = 0; key_inc = 0; key_dec = 0; tick_2hz = 0;
        compare_all();
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 1);
    endtask

    initial begin
        model_reset();
        #12;
        compare_all();
        rst_n = 1'b1;
        idle_cycles(2);

        // Reset while editing minutes: outputs clear without a clock edge.
        hour_in = 5'd7; min_in = 6'd33; sec_in = 6'd12;
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        check("pre_rst_field", field_sel, 2);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        #3 rst_n = 1'b1;
        idle_cycles(2);

        // Full set: 22:58:30 -> 00:00:30.
        hour_in = 5'd22; min_in = 6'd58; sec_in = 6'd30;
        step(1, 0, 0, 0, 1);
        check("full_fs_hr", field_sel, 1);
        step(0, 1, 0, 0, 1);
        step(0, 1, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        check("full_fs_min", field_sel, 2);
        step(0, 1, 0, 0, 1);
        step(0, 1, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        check("full_fs_sec", field_sel, 3);
        step(1, 0, 0, 0, 1);
        check("full_load", load, 1);
        check("full_hr", hour_set, 0);
        check("full_min", min_set, 0);
        check("full_sec", sec_set, 30);
        check("full_fs_commit", field_sel, 0);
        step(0, 0, 0, 0, 1);
        check("full_load_end", load, 0);

        // Timeout with a restart at the 19th tick.
        step(1, 0, 0, 0, 1);
        for (int k = 0; k < 18; k++) step(0, 0, 0, 1, 1);
        step(0, 1, 0, 1, 1);
        for (int k = 0; k < 19; k++) step(0, 0, 0, 1, 1);
        check("to_still_active", set_active, 1);
        step(0, 0, 0, 1, 1);
        check("to_idle", set_active, 0);
        check("to_no_load", load, 0);
        idle_cycles(2);

        // Mode drop beats key_sel; key_sel with mode off is ignored.
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0);
        check("drop_fs", field_sel, 0);
        check("drop_load", load, 0);
        step(1, 0, 0, 0, 0);
        check("modeoff_idle", set_active, 0);

        // key_sel wins over key_inc; tick coincident with a key keeps blink on.
        hour_in = 5'd5; min_in = 6'd10; sec_in = 6'd0;
        step(1, 0, 0, 0, 1);
        step(1, 1, 0, 0, 1);
        check("coll_fs", field_sel, 2);
        check("coll_hr", hour_set, 5);
        step(0, 0, 0, 1, 1);
        check("blink_tick", blink, 0);
        step(0, 1, 0, 1, 1);
        check("blink_forced", blink, 1);
        check("coll_min", min_set, 11);
`ifdef TIME_SET_DEC_EN
        step(0, 1, 1, 0, 1);
        check("dec_prio_min", min_set, 12);
        step(0, 0, 0, 0, 0);
        hour_in = 5'd0; min_in = 6'd0;
        step(1, 0, 0, 0, 1);
        step(0, 0, 1, 0, 1);
        check("dec_hr_wrap", hour_set, 23);
        step(1, 0, 0, 0, 1);
        step(0, 0, 1, 0, 1);
        check("dec_min_wrap", min_set, 59);
`endif
        step(0, 0, 0, 0, 0);
        idle_cycles(1);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            if (n % 40 == 0) begin
                hour_in = 5'($urandom_range(0, 23));
                min_in  = 6'($urandom_range(0, 59));
                sec_in  = 6'($urandom_range(0, 59));
            end
            step(($urandom_range(0, 7) == 0), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 60) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
- Sequences manual setting of the clock time (hours, minutes, seconds) from two debounced keys.
- Captures the running time into shadow registers when editing starts, and steps a field cursor through the fields.
- Increments the selected field with wrap-around.
- Drives a field blink for the display mux; issues a one-cycle load strobe to the timekeeping counter on commit.
- Only active while the clock (timer) mode is selected by the mode decoder.

Parameters:
TIMEOUT, 20, inactivity limit in tick_2hz pulses (20 = 10 s); on reaching it, editing aborts without load.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
mode_en  input  1  1 = clock/timer mode selected (from mode decoder)
key_sel  input  1  single-cycle pulse, debounced; enter edit / advance field
key_inc  input  1  single-cycle pulse, debounced; increment selected field
tick_2hz  input  1  single-cycle pulse at 2 Hz, synchronous to clk
hour_in  input  5  current hours, 0..23
min_in  input  6  current minutes, 0..59
sec_in  input  6  current seconds, 0..59
set_active  output  1  1 while in any EDIT state
field_sel  output  2  00 none, 01 hours, 10 minutes, 11 seconds
blink  output  1  1 = selected field visible, 0 = blanked
hour_set  output  5  shadow hours
min_set  output  6  shadow minutes
sec_set  output  6  shadow seconds
load  output  1  one-cycle strobe; timekeeper loads *_set values

Behaviour:
- Reset (rst_n=0, asynchronous, any state): state=IDLE; all outputs 0, including shadows; inactivity counter=0.
- States: IDLE, EDIT_HR, EDIT_MIN, EDIT_SEC, COMMIT. All outputs are registered.
- IDLE: on key_sel & mode_en -> EDIT_HR. On the same edge, shadows <= hour_in/min_in/sec_in, blink<=1, counter<=0. key_inc ignored.
- EDIT_HR -key_sel-> EDIT_MIN -key_sel-> EDIT_SEC -key_sel-> COMMIT.
- COMMIT: load=1 for exactly this one cycle, shadows stable; -> IDLE next cycle. Keys ignored. Latency: load asserts 1 cycle after the third key_sel following entry.
- field_sel: 01 / 10 / 11 in EDIT_HR / EDIT_MIN / EDIT_SEC; 00 in IDLE and COMMIT. set_active = (field_sel != 00).
- key_inc in an EDIT state increments the selected shadow on the next edge:
  - hour: 23 -> 0
  - min: 59 -> 0
  - sec: 59 -> 0
  - Other shadows unchanged.
- Simultaneous key_sel & key_inc: key_sel wins; the increment is discarded.
- blink in EDIT:
  - Toggles on each tick_2hz.
  - Forced to 1 on the cycle after any key_sel or key_inc; the force overrides a coincident tick.
  - blink=0 in IDLE and COMMIT.
- Inactivity counter:
  - Cleared by any key pulse; otherwise +1 per tick_2hz while in EDIT.
  - Saturates; never wraps.
  - When it reaches TIMEOUT -> IDLE. No load; shadows hold their last values.
- mode_en=0 in any EDIT state -> IDLE next edge, no load. This has priority over key_sel and timeout.
- mode_en falling in COMMIT does not cancel the load.
- Shadows are updated only on edit entry and key_inc; outside EDIT they hold.

Optional Feature:
- Macro: TIME_SET_DEC_EN.
- Defined:
  - Adds input port key_dec (1 bit, single-cycle pulse).
  - In EDIT, key_dec decrements the selected field: hour 0 -> 23, min/sec 0 -> 59.
  - key_dec clears the inactivity counter and forces blink to 1.
  - Priority: key_sel > key_inc > key_dec.
- Undefined: port absent; behaviour exactly as above.

Test Plan:
- Reset mid-edit: in EDIT_MIN, assert rst_n=0 between clk edges -> all outputs 0 immediately, state IDLE.
- Full set: hour_in=22, min_in=58, sec_in=30; key_sel; 2x key_inc; key_sel; 2x key_inc; 2x key_sel -> load pulses exactly one cycle with hour_set=0, min_set=0, sec_set=30. field_sel sequence 01, 10, 11, 00.
- Timeout: enter edit, apply 20 tick_2hz with no keys -> returns to IDLE on the 20th tick, load never asserts. A key at tick 19 restarts the count.
- Mode drop: in EDIT_HR, mode_en=0 coincident with key_sel -> IDLE, field_sel=00, no load. key_sel in IDLE with mode_en=0 -> stays IDLE.
- Collision/blink: key_sel and key_inc in the same cycle in EDIT_HR (hour=5) -> EDIT_MIN, hour_set stays 5. tick_2hz coincident with key_inc -> blink=1.
- TIME_SET_DEC_EN: hour=0, key_dec -> 23; min=0, key_dec -> 59; key_inc and key_dec together on min=10 -> 11.
